msrv32_pipe_stage: RTL and testbench

MSRV32_PIPE_STAGE -- requirements
Module: msrv32_pipe_stage

---
 rtl/msrv32_pkg.sv | 19 +
 rtl/msrv32_stage_reg.sv | 35 +++
 rtl/msrv32_pipe_stage.sv | 164 ++++++++++++++++
 tb/tb_msrv32_pipe_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 pipeline stage: occupancy states,
// default boot address and the iadder capture rule.
package msrv32_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    localparam logic [31:0] DEFAULT_BOOT_ADDRESS = 32'h0000_0000;

    // A taken branch target must be halfword aligned, so bit 0 is dropped.
    function automatic logic [31:0] capture_iadder(input logic [31:0] iadder,
                                                   input logic        branch_taken);
        return {iadder[31:1], branch_taken ? 1'b0 : iadder[0]};
    endfunction

endpackage

// File: rtl/msrv32_stage_reg.sv
// One pipeline entry: pc, iadder, side-effect enables and payload,
// with asynchronous reset and a load enable.
module msrv32_stage_reg #(
    parameter int          DATA_W   = 160,
    parameter int          CTRL_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [31:0]       next_pc,
    input  logic [31:0]       next_iadder,
    input  logic [CTRL_W-1:0] next_ctrl,
    input  logic [DATA_W-1:0] next_data,
    output logic [31:0]       pc,
    output logic [31:0]       iadder,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            iadder <= '0;
            ctrl   <= '0;
            data   <= '0;
        end else if (load) begin
            pc     <= next_pc;
            iadder <= next_iadder;
            ctrl   <= next_ctrl;
            data   <= next_data;
        end
    end

endmodule

// File: rtl/msrv32_pipe_stage.sv
// Valid/ready pipeline stage between msrv32 units; optional two-entry skid
// buffer keeps in_ready registered so out_ready never reaches upstream.
module msrv32_pipe_stage
    import msrv32_pkg::*;
#(
    parameter int          DATA_W       = 160,
    parameter int          CTRL_W       = 8,
    parameter logic [31:0] BOOT_ADDRESS = DEFAULT_BOOT_ADDRESS,
    parameter int          SKID_EN      = 1
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_iadder,
    input  logic              in_branch_taken,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_iadder,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       bubble_cnt
);

    stage_state_t      state, next_state;
    logic              in_xfer, out_xfer;
    logic              main_load, main_from_skid, skid_load;
    logic [31:0]       cap_iadder;
    logic [31:0]       main_pc, main_iadder, skid_pc, skid_iadder;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [31:0]       main_next_pc, main_next_iadder;
    logic [CTRL_W-1:0] main_next_ctrl;
    logic [DATA_W-1:0] main_next_data;

    assign out_valid  = (state != ST_EMPTY);
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    assign cap_iadder = capture_iadder(in_iadder, in_branch_taken);

    generate
        if (SKID_EN != 0) begin : g_skid_ready
            assign in_ready = (state != ST_FULL);
        end else begin : g_comb_ready
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state <= ST_EMPTY;
        else          state <= next_state;
    end

    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush_in) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_load  = 1'b1;
                        next_state = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        // Without a skid entry in_ready already implies out_ready.
                        if (SKID_EN != 0) begin
                            skid_load  = 1'b1;
                            next_state = ST_FULL;
                        end else begin
                            main_load = 1'b1;
                        end
                    end else if (out_xfer) begin
                        next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        next_state     = ST_ONE;
                    end
                end
                default: next_state = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        if (main_from_skid) begin
            main_next_pc     = skid_pc;
            main_next_iadder = skid_iadder;
            main_next_ctrl   = skid_ctrl;
            main_next_data   = skid_data;
        end else begin
            main_next_pc     = in_pc;
            main_next_iadder = cap_iadder;
            main_next_ctrl   = in_ctrl;
            main_next_data   = in_data;
        end
    end

    msrv32_stage_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .RESET_PC (BOOT_ADDRESS)
    ) u_main (
        .clk         (clk_in),
        .rst         (reset_in),
        .load        (main_load),
        .next_pc     (main_next_pc),
        .next_iadder (main_next_iadder),
        .next_ctrl   (main_next_ctrl),
        .next_data   (main_next_data),
        .pc          (main_pc),
        .iadder      (main_iadder),
        .ctrl        (main_ctrl),
        .data        (main_data)
    );

    msrv32_stage_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .RESET_PC (32'h0000_0000)
    ) u_skid (
        .clk         (clk_in),
        .rst         (reset_in),
        .load        (skid_load),
        .next_pc     (in_pc),
        .next_iadder (cap_iadder),
        .next_ctrl   (in_ctrl),
        .next_data   (in_data),
        .pc          (skid_pc),
        .iadder      (skid_iadder),
        .ctrl        (skid_ctrl),
        .data        (skid_data)
    );

    assign out_pc     = main_pc;
    assign out_iadder = main_iadder;
    assign out_data   = main_data;
    assign out_ctrl   = out_valid ? main_ctrl : '0;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            bubble_cnt <= '0;
        end else if (!out_valid && out_ready && !flush_in && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_msrv32_pipe_stage.sv
// Bench for msrv32_pipe_stage: skid and non-skid instances share stimulus and
// are each compared every cycle against a queue model of the stage.
module tb_msrv32_pipe_stage;

    localparam int          DW   = 160;
    localparam int          CW   = 8;
    localparam logic [31:0] BOOT = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush, in_valid, in_bt, out_ready;
    logic [31:0]   in_pc, in_iadder;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          rdy1, v1, rdy0, v0;
    logic [31:0]   pc1, ia1, pc0, ia0;
    logic [CW-1:0] ctrl1, ctrl0;
    logic [DW-1:0] data1, data0;
    logic [15:0]   bub1, bub0;

    always #5 clk = ~clk;

    msrv32_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .BOOT_ADDRESS(BOOT), .SKID_EN(1)) dut (
        .clk_in(clk), .reset_in(rst), .flush_in(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_pc(in_pc), .in_iadder(in_iadder),
        .in_branch_taken(in_bt), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(v1), .out_ready(out_ready), .out_pc(pc1), .out_iadder(ia1),
        .out_ctrl(ctrl1), .out_data(data1), .bubble_cnt(bub1)
    );

    msrv32_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .BOOT_ADDRESS(BOOT), .SKID_EN(0)) dut0 (
        .clk_in(clk), .reset_in(rst), .flush_in(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_pc(in_pc), .in_iadder(in_iadder),
        .in_branch_taken(in_bt), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(v0), .out_ready(out_ready), .out_pc(pc0), .out_iadder(ia0),
        .out_ctrl(ctrl0), .out_data(data0), .bubble_cnt(bub0)
    );

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   iadder;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    ent_t        q1[$];
    ent_t        q0[$];
    ent_t        disp1, disp0;
    logic [15:0] mb1, mb0;
    logic [31:0] got[$];
    int          n_acc;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q1.delete();
        q0.delete();
        disp1 = '{pc: BOOT, iadder: '0, ctrl: '0, data: '0};
        disp0 = disp1;
        mb1   = '0;
        mb0   = '0;
    endtask

    // Capacity-2 FIFO with registered ready vs capacity-1 with pass-through ready.
    task automatic model_step();
        ent_t e;
        int   s1, s0;
        bit   ri1, ri0;
        s1 = q1.size();
        s0 = q0.size();
        ri1 = (s1 < 2);
        ri0 = (s0 == 0) || out_ready;
        e.pc     = in_pc;
        e.iadder = in_bt ? (in_iadder & 32'hFFFF_FFFE) : in_iadder;
        e.ctrl   = in_ctrl;
        e.data   = in_data;
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (s1 == 0 && out_ready && mb1 != 16'hFFFF) mb1++;
            if (s0 == 0 && out_ready && mb0 != 16'hFFFF) mb0++;
            if (s1 != 0 && out_ready) void'(q1.pop_front());
            if (s0 != 0 && out_ready) void'(q0.pop_front());
            if (in_valid && ri1) q1.push_back(e);
            if (in_valid && ri0) q0.push_back(e);
            if (q1.size() != 0) disp1 = q1[0];
            if (q0.size() != 0) disp0 = q0[0];
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid1", 192'(v1), 192'(q1.size() != 0));
            chk("ready1", 192'(rdy1), 192'(q1.size() < 2));
            chk("pc1", 192'(pc1), 192'(disp1.pc));
            chk("iadder1", 192'(ia1), 192'(disp1.iadder));
            chk("data1", 192'(data1), 192'(disp1.data));
            chk("ctrl1", 192'(ctrl1), 192'((q1.size() != 0) ? disp1.ctrl : 8'h00));
            chk("bubble1", 192'(bub1), 192'(mb1));
            chk("valid0", 192'(v0), 192'(q0.size() != 0));
            chk("ready0", 192'(rdy0), 192'((q0.size() == 0) || out_ready));
            chk("pc0", 192'(pc0), 192'(disp0.pc));
            chk("iadder0", 192'(ia0), 192'(disp0.iadder));
            chk("data0", 192'(data0), 192'(disp0.data));
            chk("ctrl0", 192'(ctrl0), 192'((q0.size() != 0) ? disp0.ctrl : 8'h00));
            chk("bubble0", 192'(bub0), 192'(mb0));
        end
    end

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ia,
                         input bit bt, input bit ordy, input bit fl);
        in_valid  = v;
        in_pc     = pc;
        in_iadder = ia;
        in_bt     = bt;
        out_ready = ordy;
        flush     = fl;
        in_ctrl   = 8'h80 | pc[9:2];
        in_data   = {pc ^ 32'hA5A5_A5A5, ~pc, pc + 32'd1, pc * 32'd3, pc};
    endtask

    // Advances one clock; transfers are judged on the skid instance.
    task automatic tick();
        logic        ai, ao, fl;
        logic [31:0] opc;
        #1;
        ai  = in_valid && rdy1;
        ao  = v1 && out_ready;
        fl  = flush;
        opc = pc1;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        if (ai && !fl) n_acc++;
        if (ao && !fl) got.push_back(opc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        n_acc = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("reset_pc", 192'(pc1), 192'(32'h0000_1000));
        chk("reset_valid", 192'(v1), 192'(0));
        chk("reset_ready", 192'(rdy1), 192'(1));
        chk("reset_bubble", 192'(bub1), 192'(0));
        chk("reset_iadder", 192'(ia1), 192'(0));

        drive(1, 32'h40, 32'h105, 1, 1, 0);
        tick();
        chk("iadder_taken", 192'(ia1), 192'(32'h0000_0104));
        chk("iadder_taken_valid", 192'(v1), 192'(1));
        drive(1, 32'h44, 32'h105, 0, 1, 0);
        tick();
        chk("iadder_not_taken", 192'(ia1), 192'(32'h0000_0105));
        drive(0, 0, 0, 0, 1, 0);
        tick();

        got.delete();
        n_acc = 0;
        drive(1, 32'h0, 32'h0, 0, 0, 0);
        tick();
        drive(1, 32'h4, 32'h4, 0, 0, 0);
        tick();
        chk("full_ready", 192'(rdy1), 192'(0));
        chk("full_pc", 192'(pc1), 192'(32'h0));
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            if (n_acc < 4) drive(1, 32'(n_acc * 4), 32'(n_acc * 4), 0, 1, 0);
            else           drive(0, 0, 0, 0, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 0);
        repeat (3) tick();
        chk("order_count", 192'(got.size()), 192'(4));
        for (int i = 0; i < 4; i++)
            chk("order_pc", 192'((i < got.size()) ? got[i] : 32'hFFFF_FFFF), 192'(i * 4));

        drive(1, 32'h200, 32'h200, 0, 0, 0);
        tick();
        drive(1, 32'h204, 32'h204, 0, 0, 0);
        tick();
        chk("flush_pre_ready", 192'(rdy1), 192'(0));
        drive(1, 32'hDEAD0, 32'hDEAD0, 0, 0, 1);
        tick();
        chk("flush_valid", 192'(v1), 192'(0));
        chk("flush_ctrl", 192'(ctrl1), 192'(0));
        chk("flush_ready", 192'(rdy1), 192'(1));
        chk("flush_hold_pc", 192'(pc1), 192'(32'h200));
        got.delete();
        drive(0, 0, 0, 0, 1, 0);
        repeat (3) tick();
        chk("flush_nothing_out", 192'(got.size()), 192'(0));

        drive(1, 32'h300, 32'h300, 0, 0, 0);
        tick();
        drive(1, 32'h304, 32'h304, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("midreset_valid", 192'(v1), 192'(0));
        chk("midreset_ready", 192'(rdy1), 192'(1));
        chk("midreset_pc", 192'(pc1), 192'(32'h0000_1000));
        chk("midreset_iadder", 192'(ia1), 192'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        drive(1, 32'h500, 32'h501, 1, 0, 0);
        tick();
        chk("postreset_valid", 192'(v1), 192'(1));
        chk("postreset_pc", 192'(pc1), 192'(32'h500));
        chk("postreset_iadder", 192'(ia1), 192'(32'h500));
        chk("postreset_ready", 192'(rdy1), 192'(1));
        drive(0, 0, 0, 0, 1, 0);
        tick();

        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h100 + 32'(4 * i), 32'h100 + 32'(4 * i), 0, 1, 0);
            tick();
            chk("noskid_valid", 192'(v0), 192'(1));
            chk("noskid_pc", 192'(pc0), 192'(32'h100 + 32'(4 * i)));
            chk("skid_stream_pc", 192'(pc1), 192'(32'h100 + 32'(4 * i)));
        end
        drive(0, 0, 0, 0, 1, 0);
        tick();
        chk("noskid_drained", 192'(v0), 192'(0));

        repeat (66000) tick();
        chk("bubble_sat1", 192'(bub1), 192'(16'hFFFF));
        chk("bubble_sat0", 192'(bub0), 192'(16'hFFFF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
